// File: rtl/simon_seq_ctrl_if.sv
// simon_seq_ctrl_if: game-control and display bus between the Simon sequencer and its surroundings.
// The master side drives start/symbol/button inputs; the slave side (the sequencer) drives display and status.
interface simon_seq_ctrl_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CODE_W = 5
);
    logic                       start;
    logic [CODE_W-1:0]          sym_in;
    logic                       btn_valid;
    logic [CODE_W-1:0]          btn_code;
    logic [DEPTH*CODE_W-1:0]    seq;
    logic [3:0]                 level;
    logic                       accept;
    logic                       win;
    logic                       lose;

    modport master (
        output start, sym_in, btn_valid, btn_code,
        input  seq, level, accept, win, lose
    );

    modport slave (
        input  start, sym_in, btn_valid, btn_code,
        output seq, level, accept, win, lose
    );
endinterface

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: Simon Says sequencer - grows a symbol pattern, plays it back, checks player presses.
// Define SIMON_TIMEOUT_EN to make an idle INPUT phase expire into LOSE after TIMEOUT_TICKS cycles.
module simon_seq_ctrl #(
    parameter int unsigned       DEPTH         = 8,
    parameter int unsigned       CODE_W        = 5,
    parameter int unsigned       SHOW_TICKS    = 50,
    parameter int unsigned       GAP_TICKS     = 10,
    parameter logic [CODE_W-1:0] BLANK         = '0,
    parameter int unsigned       TIMEOUT_TICKS = 500
) (
    input  logic            clk,
    input  logic            reset,
    simon_seq_ctrl_if.slave bus
);
    localparam int unsigned LVL_W     = 4;
    localparam int unsigned PLAY_MAX  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned TICK_MAX  = (PLAY_MAX > TIMEOUT_TICKS) ? PLAY_MAX : TIMEOUT_TICKS;
    localparam int unsigned TICK_W    = $clog2(TICK_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHOW,
        GAP,
        INPUT,
        WIN,
        LOSE
    } state_t;

    state_t                         state, state_n;
    logic [DEPTH-1:0][CODE_W-1:0]   mem, mem_n;
    logic [LVL_W-1:0]               level, level_n;
    logic [LVL_W-1:0]               idx, idx_n;
    logic [TICK_W-1:0]              tick, tick_n;

    logic [DEPTH-1:0][CODE_W-1:0]   seq_q, seq_n;
    logic                           accept_q, accept_n;
    logic                           win_q, win_n;
    logic                           lose_q, lose_n;

    logic [CODE_W-1:0]              cur_sym;
    logic                           last_slot;

    // State, pattern and registered display/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mem      <= {DEPTH{BLANK}};
            level    <= '0;
            idx      <= '0;
            tick     <= '0;
            seq_q    <= {DEPTH{BLANK}};
            accept_q <= 1'b0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
        end else begin
            state    <= state_n;
            mem      <= mem_n;
            level    <= level_n;
            idx      <= idx_n;
            tick     <= tick_n;
            seq_q    <= seq_n;
            accept_q <= accept_n;
            win_q    <= win_n;
            lose_q   <= lose_n;
        end
    end

    // Symbol at the current index and whether it is the last one of the pattern.
    always_comb begin
        cur_sym = BLANK;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == idx) begin
                cur_sym = mem[i];
            end
        end
        last_slot = ((idx + LVL_W'(1)) == level);
    end

    // Next-state logic; start overrides everything, including a same-cycle press.
    always_comb begin
        state_n = state;
        mem_n   = mem;
        level_n = level;
        idx_n   = idx;
        tick_n  = tick;

        if (bus.start) begin
            mem_n   = {DEPTH{BLANK}};
            level_n = '0;
            idx_n   = '0;
            tick_n  = '0;
            state_n = ADD;
        end else begin
            case (state)
                ADD: begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (LVL_W'(i) == level) begin
                            mem_n[i] = bus.sym_in;
                        end
                    end
                    level_n = level + LVL_W'(1);
                    idx_n   = '0;
                    tick_n  = '0;
                    state_n = SHOW;
                end
                SHOW: begin
                    if (tick == TICK_W'(SHOW_TICKS - 1)) begin
                        tick_n  = '0;
                        state_n = GAP;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
                GAP: begin
                    if (tick == TICK_W'(GAP_TICKS - 1)) begin
                        tick_n = '0;
                        if (last_slot) begin
                            idx_n   = '0;
                            state_n = INPUT;
                        end else begin
                            idx_n   = idx + LVL_W'(1);
                            state_n = SHOW;
                        end
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
                end
                INPUT: begin
                    if (bus.btn_valid) begin
                        if (bus.btn_code == cur_sym) begin
                            idx_n  = idx + LVL_W'(1);
                            tick_n = '0;
                            if (last_slot) begin
                                state_n = (level == LVL_W'(DEPTH)) ? WIN : ADD;
                            end
                        end else begin
                            state_n = LOSE;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (tick == TICK_W'(TIMEOUT_TICKS - 1)) begin
                        state_n = LOSE;
                    end else begin
                        tick_n = tick + TICK_W'(1);
                    end
`else
                    else begin
                        tick_n = '0;
                    end
`endif
                end
                IDLE, WIN, LOSE: begin
                    state_n = state;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Display/status decode of the upcoming state so the registered outputs track it exactly.
    always_comb begin
        seq_n    = {DEPTH{BLANK}};
        accept_n = (state_n == INPUT);
        win_n    = (state_n == WIN);
        lose_n   = (state_n == LOSE);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            case (state_n)
                SHOW: begin
                    if (LVL_W'(i) == idx_n) begin
                        seq_n[i] = mem_n[i];
                    end
                end
                INPUT: begin
                    if (LVL_W'(i) < idx_n) begin
                        seq_n[i] = mem_n[i];
                    end
                end
                WIN, LOSE: begin
                    seq_n[i] = mem_n[i];
                end
                default: begin
                    seq_n[i] = BLANK;
                end
            endcase
        end
    end

    assign bus.seq    = seq_q;
    assign bus.level  = level;
    assign bus.accept = accept_q;
    assign bus.win    = win_q;
    assign bus.lose   = lose_q;

endmodule
